// File: rtl/trie_lookup_seq.sv
// trie_lookup_seq: serial 4-bit-stride longest-prefix trie walk over one shared stage_ram read port.
// Define TRIE_LOOKUP_STATS_EN to add the stat_lookups/stat_hits counters.
module trie_lookup_seq #(
    parameter int         ADDR_LEN   = 14,
    parameter int         DATA_WIDTH = 19,
    parameter logic [7:0] DEFAULT_NH = 8'd0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_ip,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_hit,
    output logic [7:0]            resp_nexthop,
    output logic [3:0]            resp_depth,
    output logic [ADDR_LEN-1:0]   ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_dout
`ifdef TRIE_LOOKUP_STATS_EN
    ,
    output logic [31:0]           stat_lookups,
    output logic [31:0]           stat_hits
`endif
);
    localparam int BLK_W = ADDR_LEN - 4;
    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;
    state_t            r_state;
    logic [31:0]       r_ip;
    logic [2:0]        r_level;
    logic              r_hit;
    logic [7:0]        r_nh;
    logic              w_exist;
    logic [7:0]        w_nexthop;
    logic [BLK_W-1:0]  w_next_blk;
    logic              w_hit;
    logic [7:0]        w_nh;
    logic              w_descend;
    assign w_exist    = ram_dout[DATA_WIDTH-1];
    assign w_nexthop  = ram_dout[DATA_WIDTH-2 -: 8];
    assign w_next_blk = ram_dout[BLK_W-1:0];
    // a deeper existing entry overrides, a missing one keeps what was found so far
    assign w_hit      = r_hit | w_exist;
    assign w_nh       = w_exist ? w_nexthop : r_nh;
    assign w_descend  = (w_next_blk != '0) && (r_level != 3'd7);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_ip         <= '0;
            r_level      <= '0;
            r_hit        <= 1'b0;
            r_nh         <= DEFAULT_NH;
            req_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_hit     <= 1'b0;
            resp_nexthop <= DEFAULT_NH;
            resp_depth   <= '0;
            ram_addr     <= '0;
`ifdef TRIE_LOOKUP_STATS_EN
            stat_lookups <= '0;
            stat_hits    <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: if (req_valid) begin
                    r_state   <= ADDR;
                    req_ready <= 1'b0;
                    r_ip      <= req_ip;
                    ram_addr  <= {{BLK_W{1'b0}}, req_ip[31:28]};
                    r_level   <= '0;
                    r_hit     <= 1'b0;
                    r_nh      <= DEFAULT_NH;
                end
                ADDR: r_state <= DATA;
                DATA: begin
                    r_hit <= w_hit;
                    r_nh  <= w_nh;
                    if (w_descend) begin
                        // r_ip is kept shifted so the next level's nibble is always at [27:24]
                        ram_addr <= {w_next_blk, r_ip[27:24]};
                        r_ip     <= r_ip << 4;
                        r_level  <= r_level + 3'd1;
                        r_state  <= ADDR;
                    end else begin
                        resp_hit     <= w_hit;
                        resp_nexthop <= w_nh;
                        resp_depth   <= 4'(r_level) + 4'd1;
                        resp_valid   <= 1'b1;
                        r_state      <= DONE;
                    end
                end
                DONE: if (resp_ready) begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    r_state    <= IDLE;
`ifdef TRIE_LOOKUP_STATS_EN
                    stat_lookups <= stat_lookups + 32'd1;
                    stat_hits    <= stat_hits + {31'd0, resp_hit};
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_trie_lookup_seq.sv
// tb_trie_lookup_seq: scoreboard bench for trie_lookup_seq with a behavioural stage_ram and trie-walk model.
module tb_trie_lookup_seq;
    localparam logic [7:0] DEF = 8'd0;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_ip;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_hit;
    logic [7:0]  resp_nexthop;
    logic [3:0]  resp_depth;
    logic [13:0] ram_addr;
    logic [18:0] ram_dout;
`ifdef TRIE_LOOKUP_STATS_EN
    logic [31:0] stat_lookups;
    logic [31:0] stat_hits;
`endif

    trie_lookup_seq dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_ip(req_ip),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
        .resp_nexthop(resp_nexthop), .resp_depth(resp_depth),
        .ram_addr(ram_addr), .ram_dout(ram_dout)
`ifdef TRIE_LOOKUP_STATS_EN
        , .stat_lookups(stat_lookups), .stat_hits(stat_hits)
`endif
    );

    always #5 clk = ~clk;

    logic [18:0] mem [0:16383];
    always @(posedge clk) ram_dout <= mem[ram_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       hit;
        logic [7:0] nh;
        logic [3:0] depth;
        int         e0;
    } exp_t;
    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int last_hs = -1;
    int n_lookups = 0;
    int n_hits = 0;
    bit stall = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // longest-prefix walk straight from the trie rules: up to 8 nibble levels from block 0
    function automatic exp_t model(input logic [31:0] ip);
        exp_t r;
        logic [9:0] blk = '0;
        logic [18:0] w;
        r.hit = 1'b0; r.nh = DEF; r.depth = '0; r.e0 = 0;
        for (int k = 0; k < 8; k++) begin
            w = mem[{blk, ip[31-4*k -: 4]}];
            r.depth = 4'(k + 1);
            if (w[18]) begin
                r.hit = 1'b1;
                r.nh = w[17:10];
            end
            if (w[9:0] == 10'd0) break;
            blk = w[9:0];
        end
        return r;
    endfunction

    task automatic send(input logic [31:0] ip, input bit use_model,
                        input logic hit, input logic [7:0] nh, input logic [3:0] depth);
        exp_t e;
        int t = 0;
        req_valid = 1'b1;
        req_ip = ip;
        while (!req_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("accept_wait", req_ready, 1);
        if (req_ready) begin
            if (use_model) e = model(ip);
            else begin
                e.hit = hit; e.nh = nh; e.depth = depth;
            end
            e.e0 = cyc + 1;
            chk("accept_after_handshake", e.e0 > last_hs, 1);
            exp_q.push_back(e);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((exp_q.size() != 0 || !req_ready) && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("drain", (exp_q.size() == 0) && req_ready, 1);
    endtask

    task automatic chk_reset_vals();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_hit", resp_hit, 0);
        chk("rst_resp_depth", resp_depth, 0);
        chk("rst_resp_nexthop", resp_nexthop, DEF);
        chk("rst_ram_addr", ram_addr, 0);
    endtask

    // monitor: pops the scoreboard on each new response, checks it while held
    initial begin
        exp_t cur;
        bit prev_v = 1'b0;
        cur.hit = 1'b0; cur.nh = DEF; cur.depth = '0; cur.e0 = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 1'b0;
                n_lookups = 0;
                n_hits = 0;
            end else begin
                resp_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
                if (resp_valid) begin
                    if (!prev_v) begin
                        if (exp_q.size() == 0) chk("unexpected_resp", resp_valid, 0);
                        else begin
                            cur = exp_q.pop_front();
                            chk("resp_latency", cyc - cur.e0, 2 * cur.depth);
                        end
                    end
                    chk("resp_hit", resp_hit, cur.hit);
                    chk("resp_nexthop", resp_nexthop, cur.nh);
                    chk("resp_depth", resp_depth, cur.depth);
                    chk("done_req_ready", req_ready, 0);
                    if (resp_ready) begin
                        last_hs = cyc + 1;
                        n_lookups++;
                        n_hits += int'(resp_hit);
                    end
                end
                prev_v = resp_valid && !resp_ready;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        req_valid = 1'b0;
        req_ip = '0;
        resp_ready = 1'b0;
        for (int a = 0; a < 16384; a++) mem[a] = '0;
        #3 rst_n = 1'b0;
        #1 chk_reset_vals();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // root miss
        mem[14'h00C] = {1'b0, 8'd0, 10'd0};
        send(32'hC0A80001, 0, 1'b0, DEF, 4'd1);
        wait_idle();

        // longest match over three levels
        mem[14'h00C] = {1'b1, 8'd5, 10'd3};
        mem[14'h030] = {1'b0, 8'd0, 10'd7};
        mem[14'h07A] = {1'b1, 8'd9, 10'd0};
        send(32'hC0A80001, 0, 1'b1, 8'd9, 4'd3);
        wait_idle();

        // full depth chain on 12345678; level 7 points at block 9 that must never be read
        for (int k = 0; k < 8; k++)
            mem[{10'(k), 4'(k + 1)}] = {1'b1, (k == 7) ? 8'h42 : 8'(k + 1), (k == 7) ? 10'd9 : 10'(k + 1)};
        send(32'h12345678, 0, 1'b1, 8'h42, 4'd8);
        wait_idle();
        chk("last_ram_addr", ram_addr, 14'h078);

        // backpressure with a second request held pending
        stall = 1'b1;
        send(32'hC0A80001, 1, 1'b0, DEF, 4'd0);
        req_valid = 1'b1;
        req_ip = 32'h12345678;
        begin
            int t = 0;
            while (!resp_valid && t < 100) begin
                chk("busy_req_ready", req_ready, 0);
                @(negedge clk);
                t++;
            end
        end
        chk("bp_resp_valid", resp_valid, 1);
        repeat (10) begin
            @(negedge clk);
            chk("bp_req_ready", req_ready, 0);
            chk("bp_resp_valid_hold", resp_valid, 1);
        end
        stall = 1'b0;
        send(32'h12345678, 1, 1'b0, DEF, 4'd0);
        wait_idle();

        // reset during the DATA cycle of level 2
        send(32'h12345678, 1, 1'b0, DEF, 4'd0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        #1 chk_reset_vals();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        last_hs = -1;
        repeat (3) @(negedge clk);
        send(32'h12345678, 0, 1'b1, 8'h42, 4'd8);
        wait_idle();

        // random tries confined to blocks 0..15
        for (int r = 0; r < 3; r++) begin
            wait_idle();
            for (int a = 0; a < 256; a++)
                mem[a] = {1'($urandom_range(0, 1)), 8'($urandom),
                          ($urandom_range(0, 2) == 0) ? 10'd0 : 10'($urandom_range(1, 15))};
            for (int i = 0; i < 15; i++) send($urandom, 1, 1'b0, DEF, 4'd0);
        end
        wait_idle();
        repeat (2) @(negedge clk);
`ifdef TRIE_LOOKUP_STATS_EN
        chk("stat_lookups", stat_lookups, n_lookups);
        chk("stat_hits", stat_hits, n_hits);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
